// File: rtl/first_nios1_system_cpu_oci_dct_packer.sv
// first_nios1_system_cpu_oci_dct_packer
// Packs 2-bit trace fragments into 30-bit DCT words (15 fragments each) and
// hands completed or flushed words to the trace sink.
//
// Output handshake: a word is transferred on every rising clk edge where
// out_valid and out_ready are both 1. While out_valid=1 and out_ready=0,
// out_buffer/out_count hold steady. The output register counts as free in
// a cycle where out_valid=0 or out_ready=1, so accepting the old word and
// loading a new word can happen on the same edge.
//
// Optional feature: define FIRST_NIOS1_DCT_DROP_COUNT_EN to add the
// saturating 8-bit drop_count output.
//
// The accumulator FSM state is held in state_q. It can be observed
// hierarchically for debug: EMPTY, PARTIAL, FULL, or FLUSH_PEND (a flush
// is waiting for the output register).
module first_nios1_system_cpu_oci_dct_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        frag_valid,
  input  logic [1:0]  frag_data,
  input  logic        flush,
  input  logic        test_ending,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [29:0] out_buffer,
  output logic [3:0]  out_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        ovf
`ifdef FIRST_NIOS1_DCT_DROP_COUNT_EN
  ,
  output logic [7:0]  drop_count
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY      = 2'd0,
    ST_PARTIAL    = 2'd1,
    ST_FULL       = 2'd2,
    ST_FLUSH_PEND = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [29:0] acc_buf_q, acc_buf_d;
  logic [3:0]  acc_cnt_q, acc_cnt_d;
  logic        out_valid_d;
  logic [29:0] out_buffer_d;
  logic [3:0]  out_count_d;
  logic        ovf_d;

  logic        out_free;
  logic        flush_req;
  logic        blocked;
  logic        frag_take;
  logic        frag_drop;
  logic [29:0] merged_buf;
  logic [3:0]  merged_cnt;
  logic        xfer;

  // Next-state, accumulator merge, and output-register load decisions.
  always_comb begin
    out_free   = !out_valid || out_ready;
    flush_req  = flush || test_ending;
    // While FULL or waiting to flush, the accumulator must not change.
    blocked    = (state_q == ST_FULL) || (state_q == ST_FLUSH_PEND);
    frag_take  = frag_valid && !blocked;
    frag_drop  = frag_valid && blocked;

    merged_buf = acc_buf_q;
    merged_cnt = acc_cnt_q;
    if (frag_take) begin
      merged_buf = acc_buf_q | ({28'd0, frag_data} << {acc_cnt_q, 1'b0});
      merged_cnt = acc_cnt_q + 4'd1;
    end

    state_d   = state_q;
    acc_buf_d = merged_buf;
    acc_cnt_d = merged_cnt;
    xfer      = 1'b0;

    if (blocked) begin
      if (out_free) begin
        xfer      = 1'b1;
        acc_buf_d = 30'd0;
        acc_cnt_d = 4'd0;
        state_d   = ST_EMPTY;
      end
    end else if (merged_cnt == 4'd15) begin
      if (out_free) begin
        xfer      = 1'b1;
        acc_buf_d = 30'd0;
        acc_cnt_d = 4'd0;
        state_d   = ST_EMPTY;
      end else begin
        state_d   = ST_FULL;
      end
    end else if (flush_req && (merged_cnt != 4'd0)) begin
      if (out_free) begin
        xfer      = 1'b1;
        acc_buf_d = 30'd0;
        acc_cnt_d = 4'd0;
        state_d   = ST_EMPTY;
      end else begin
        state_d   = ST_FLUSH_PEND;
      end
    end else begin
      state_d = (merged_cnt == 4'd0) ? ST_EMPTY : ST_PARTIAL;
    end

    out_valid_d  = out_valid;
    out_buffer_d = out_buffer;
    out_count_d  = out_count;
    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_buffer_d = merged_buf;
      out_count_d  = merged_cnt;
    end

    ovf_d = ovf || frag_drop;
  end

  // State, accumulator, output register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      acc_buf_q  <= 30'd0;
      acc_cnt_q  <= 4'd0;
      out_valid  <= 1'b0;
      out_buffer <= 30'd0;
      out_count  <= 4'd0;
      ovf        <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_buf_q  <= acc_buf_d;
      acc_cnt_q  <= acc_cnt_d;
      out_valid  <= out_valid_d;
      out_buffer <= out_buffer_d;
      out_count  <= out_count_d;
      ovf        <= ovf_d;
    end
  end

  assign dct_buffer = acc_buf_q;
  assign dct_count  = acc_cnt_q;

`ifdef FIRST_NIOS1_DCT_DROP_COUNT_EN
  // Saturating count of dropped fragments.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (frag_drop && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_first_nios1_system_cpu_oci_dct_packer.sv
// Directed bench for first_nios1_system_cpu_oci_dct_packer.
module tb_first_nios1_system_cpu_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        frag_valid;
  logic [1:0]  frag_data;
  logic        flush;
  logic        test_ending;
  logic        out_ready;
  logic        out_valid;
  logic [29:0] out_buffer;
  logic [3:0]  out_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        ovf;
`ifdef FIRST_NIOS1_DCT_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  int checks;
  int errors;
  logic [29:0] exp_word;

  first_nios1_system_cpu_oci_dct_packer dut (
    .clk         (clk),
    .reset       (reset),
    .frag_valid  (frag_valid),
    .frag_data   (frag_data),
    .flush       (flush),
    .test_ending (test_ending),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_buffer  (out_buffer),
    .out_count   (out_count),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .ovf         (ovf)
`ifdef FIRST_NIOS1_DCT_DROP_COUNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic fv, input logic [1:0] fd, input logic fl,
                      input logic te, input logic rdy);
    frag_valid  = fv;
    frag_data   = fd;
    flush       = fl;
    test_ending = te;
    out_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " out_valid"},  {31'd0, out_valid}, 32'd0);
    check({tag, " out_buffer"}, {2'd0, out_buffer}, 32'd0);
    check({tag, " out_count"},  {28'd0, out_count}, 32'd0);
    check({tag, " dct_buffer"}, {2'd0, dct_buffer}, 32'd0);
    check({tag, " dct_count"},  {28'd0, dct_count}, 32'd0);
    check({tag, " ovf"},        {31'd0, ovf},       32'd0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    frag_valid  = 1'b0;
    frag_data   = 2'd0;
    flush       = 1'b0;
    test_ending = 1'b0;
    out_ready   = 1'b0;

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Full word: fragments 0,1,2,3,... with out_ready=1
    exp_word = 30'd0;
    for (int n = 0; n < 15; n++) begin
      exp_word = exp_word | (30'(n % 4) << (2 * n));
      step(1'b1, 2'(n % 4), 1'b0, 1'b0, 1'b1);
      if (n == 13) check("full14 dct_count", {28'd0, dct_count}, 32'd14);
    end
    check("full out_valid",  {31'd0, out_valid}, 32'd1);
    check("full out_buffer", {2'd0, out_buffer}, {2'd0, exp_word});
    check("full out_buffer const", {2'd0, out_buffer}, 32'h24E4E4E4);
    check("full out_count",  {28'd0, out_count}, 32'd15);
    check("full dct_count",  {28'd0, dct_count}, 32'd0);
    check("full ovf",        {31'd0, ovf}, 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("full accepted",   {31'd0, out_valid}, 32'd0);

    // Partial flush: 3,2,1 then flush
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    check("part dct_buffer", {2'd0, dct_buffer}, 32'h1B);
    check("part dct_count",  {28'd0, dct_count}, 32'd3);
    check("part no word yet", {31'd0, out_valid}, 32'd0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    check("part out_valid",  {31'd0, out_valid}, 32'd1);
    check("part out_buffer", {2'd0, out_buffer}, 32'h1B);
    check("part out_count",  {28'd0, out_count}, 32'd3);
    check("part dct_count",  {28'd0, dct_count}, 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("part accepted",   {31'd0, out_valid}, 32'd0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    check("empty flush no word", {31'd0, out_valid}, 32'd0);

    // Backpressure: 30 fragments of 3 with out_ready=0
    for (int n = 0; n < 30; n++) begin
      step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
      if (n == 14) begin
        check("bp first valid",  {31'd0, out_valid}, 32'd1);
        check("bp first buffer", {2'd0, out_buffer}, 32'h3FFFFFFF);
        check("bp dct after first", {28'd0, dct_count}, 32'd0);
      end
    end
    check("bp held valid",  {31'd0, out_valid}, 32'd1);
    check("bp held buffer", {2'd0, out_buffer}, 32'h3FFFFFFF);
    check("bp held count",  {28'd0, out_count}, 32'd15);
    check("bp full dct_count", {28'd0, dct_count}, 32'd15);
    check("bp full dct_buffer", {2'd0, dct_buffer}, 32'h3FFFFFFF);
    check("bp no ovf yet",  {31'd0, ovf}, 32'd0);

    // Overflow: 4 more fragments while FULL
    for (int n = 0; n < 4; n++) step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check("ovf set",        {31'd0, ovf}, 32'd1);
    check("ovf dct_count",  {28'd0, dct_count}, 32'd15);
    check("ovf dct_buffer", {2'd0, dct_buffer}, 32'h3FFFFFFF);
`ifdef FIRST_NIOS1_DCT_DROP_COUNT_EN
    check("drop_count", {24'd0, drop_count}, 32'd4);
`endif
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("bp word2 valid",  {31'd0, out_valid}, 32'd1);
    check("bp word2 buffer", {2'd0, out_buffer}, 32'h3FFFFFFF);
    check("bp word2 count",  {28'd0, out_count}, 32'd15);
    check("bp drained dct",  {28'd0, dct_count}, 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("bp done valid",   {31'd0, out_valid}, 32'd0);
    check("ovf sticky",      {31'd0, ovf}, 32'd1);

    // Simultaneous fragment and test_ending
    do_reset();
    check("reset clears ovf", {31'd0, ovf}, 32'd0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
    check("sim out_valid",  {31'd0, out_valid}, 32'd1);
    check("sim out_buffer", {2'd0, out_buffer}, 32'h9);
    check("sim out_count",  {28'd0, out_count}, 32'd2);
    check("sim dct_count",  {28'd0, dct_count}, 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-operation: word held in output, 7 fragments accumulated
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    check("mid out_valid", {31'd0, out_valid}, 32'd1);
    check("mid out_count", {28'd0, out_count}, 32'd1);
    for (int n = 0; n < 7; n++) step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    check("mid dct_count",  {28'd0, dct_count}, 32'd7);
    check("mid dct_buffer", {2'd0, dct_buffer}, 32'h1555);
    do_reset();
    check_all_zero("midreset");

    // Flush pending while output blocked; fragment during pending is dropped
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    check("pend first buffer", {2'd0, out_buffer}, 32'h3);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("pend held buffer", {2'd0, out_buffer}, 32'h3);
    check("pend dct_count",   {28'd0, dct_count}, 32'd1);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    check("pend drop ovf",    {31'd0, ovf}, 32'd1);
    check("pend dct_buffer",  {2'd0, dct_buffer}, 32'h1);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("pend out_valid",   {31'd0, out_valid}, 32'd1);
    check("pend out_buffer",  {2'd0, out_buffer}, 32'h1);
    check("pend out_count",   {28'd0, out_count}, 32'd1);
    check("pend dct_count 0", {28'd0, dct_count}, 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("pend accepted",    {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
